// File: rtl/mcu0_pkg.sv
// mcu0_pkg: shared types and constants for the mcu0 core.
// Holds the instruction word width, the fetch FSM state encoding, the
// native prefetch queue entry and the opcode constants used by execute.
package mcu0_pkg;

  localparam int WORD_W = 16;
  localparam int PC_W   = 12;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FETCH = 2'd1,
    DROP  = 2'd2
  } fetch_state_e;

  // Queue entry for the native 12-bit mcu0 address space; the fetch unit
  // rebuilds the same layout at its own AW so other widths stay exact.
  typedef struct packed {
    logic [PC_W-1:0]   pc;
    logic [WORD_W-1:0] data;
  } fetch_entry_t;

  // Opcode field (upper nibble of the instruction word)
  localparam logic [3:0] OP_LDA  = 4'h0;
  localparam logic [3:0] OP_STA  = 4'h1;
  localparam logic [3:0] OP_ADD  = 4'h2;
  localparam logic [3:0] OP_SUB  = 4'h3;
  localparam logic [3:0] OP_JMP  = 4'h4;
  localparam logic [3:0] OP_JZ   = 4'h5;
  localparam logic [3:0] OP_JN   = 4'h6;
  localparam logic [3:0] OP_JSUB = 4'h7;
  localparam logic [3:0] OP_RET  = 4'h8;
  localparam logic [3:0] OP_IRET = 4'h9;
  localparam logic [3:0] OP_SYS  = 4'hF;

endpackage

// File: rtl/mcu0_fetch_fifo.sv
// mcu0_fetch_fifo: DEPTH-entry circular buffer for the prefetch queue.
// Wrapping read/write pointers, synchronous flush with priority over
// push and pop, occupancy count and a zeroed head when empty.
module mcu0_fetch_fifo #(
  parameter int  DEPTH   = 4,
  parameter type entry_t = mcu0_pkg::fetch_entry_t
) (
  input  logic                         clock,
  input  logic                         reset,
  input  logic                         push,
  input  entry_t                       push_entry,
  input  logic                         pop,
  input  logic                         flush,
  output entry_t                       head,
  output logic                         head_valid,
  output logic [$clog2(DEPTH+1)-1:0]   count
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH+1);

  entry_t          mem_q [DEPTH];
  logic [PW-1:0]   rd_ptr_q, rd_ptr_d;
  logic [PW-1:0]   wr_ptr_q, wr_ptr_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic            do_push, do_pop;

  // Pointer/count update; pointers wrap naturally since DEPTH is a power of 2
  always_comb begin
    do_push  = push && (cnt_q != CW'(DEPTH));
    do_pop   = pop && (cnt_q != '0);
    rd_ptr_d = rd_ptr_q + PW'(do_pop);
    wr_ptr_d = wr_ptr_q + PW'(do_push);
    cnt_d    = cnt_q + CW'(do_push) - CW'(do_pop);
    if (flush) begin
      rd_ptr_d = '0;
      wr_ptr_d = '0;
      cnt_d    = '0;
    end
  end

  // Pointer and count registers
  always_ff @(posedge clock) begin
    if (reset) begin
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      cnt_q    <= '0;
    end else begin
      rd_ptr_q <= rd_ptr_d;
      wr_ptr_q <= wr_ptr_d;
      cnt_q    <= cnt_d;
    end
  end

  // Entry storage; a flushed push is simply not written
  always_ff @(posedge clock) begin
    if (do_push && !flush) begin
      mem_q[wr_ptr_q] <= push_entry;
    end
  end

  // Head presentation, forced to zero while empty
  always_comb begin
    head_valid = (cnt_q != '0);
    head       = head_valid ? mem_q[rd_ptr_q] : '0;
  end

  assign count = cnt_q;

endmodule

// File: rtl/mcu0_fetch.sv
// mcu0_fetch: instruction fetch unit with prefetch queue for mcu0.
// Single-outstanding memory port, valid/ready output to execute, redirect
// flushes the queue and restarts fetch (an in-flight read is drained in DROP).
// Optional: define MCU0_FETCH_STATS_EN to add stat_fetches/stat_flushes.
module mcu0_fetch
  import mcu0_pkg::*;
#(
  parameter int          AW       = 12,
  parameter int          DEPTH    = 4,
  parameter int unsigned RESET_PC = 0
) (
  input  logic                        clock,
  input  logic                        reset,
  output logic                        mem_req,
  output logic [AW-1:0]               mem_addr,
  input  logic                        mem_ack,
  input  logic [WORD_W-1:0]           mem_rdata,
  output logic                        ir_valid,
  output logic [WORD_W-1:0]           ir_data,
  output logic [AW-1:0]               ir_pc,
  input  logic                        ir_ready,
  input  logic                        redirect,
  input  logic [AW-1:0]               redirect_pc,
`ifdef MCU0_FETCH_STATS_EN
  output logic [15:0]                 stat_fetches,
  output logic [15:0]                 stat_flushes,
`endif
  output logic [$clog2(DEPTH+1)-1:0]  ir_count
);

  localparam int CW = $clog2(DEPTH+1);

  typedef struct packed {
    logic [AW-1:0]     pc;
    logic [WORD_W-1:0] data;
  } entry_t;

  fetch_state_e  state_q, state_d;
  logic [AW-1:0] fpc_q, fpc_d;
  logic [AW-1:0] addr_q, addr_d;
  logic          push, pop;
  logic [CW-1:0] count, post_cnt;
  entry_t        push_entry, head;
  logic          head_valid;

  assign pop              = head_valid && ir_ready;
  assign push_entry.pc    = addr_q;
  assign push_entry.data  = mem_rdata;
  // Occupancy after an enqueue at this edge (never exceeds DEPTH)
  assign post_cnt         = count + CW'(1) - CW'(pop);

  mcu0_fetch_fifo #(
    .DEPTH   (DEPTH),
    .entry_t (entry_t)
  ) u_fifo (
    .clock      (clock),
    .reset      (reset),
    .push       (push),
    .push_entry (push_entry),
    .pop        (pop),
    .flush      (redirect),
    .head       (head),
    .head_valid (head_valid),
    .count      (count)
  );

  // FSM state, fetch pointer and held request address
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q <= IDLE;
      fpc_q   <= AW'(RESET_PC);
      addr_q  <= AW'(RESET_PC);
    end else begin
      state_q <= state_d;
      fpc_q   <= fpc_d;
      addr_q  <= addr_d;
    end
  end

  // Next state: redirect wins; an ack in the redirect cycle is discarded
  always_comb begin
    state_d = state_q;
    fpc_d   = fpc_q;
    addr_d  = addr_q;
    push    = 1'b0;
    case (state_q)
      IDLE: begin
        if (redirect) begin
          state_d = FETCH;
          fpc_d   = redirect_pc;
          addr_d  = redirect_pc;
        end else if (count < CW'(DEPTH)) begin
          state_d = FETCH;
          addr_d  = fpc_q;
        end
      end
      FETCH: begin
        if (redirect) begin
          fpc_d = redirect_pc;
          if (mem_ack) begin
            addr_d = redirect_pc;
          end else begin
            state_d = DROP;
          end
        end else if (mem_ack) begin
          push    = 1'b1;
          fpc_d   = addr_q + AW'(1);
          addr_d  = addr_q + AW'(1);
          state_d = (post_cnt < CW'(DEPTH)) ? FETCH : IDLE;
        end
      end
      DROP: begin
        if (redirect) begin
          fpc_d = redirect_pc;
          if (mem_ack) begin
            state_d = FETCH;
            addr_d  = redirect_pc;
          end
        end else if (mem_ack) begin
          state_d = FETCH;
          addr_d  = fpc_q;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Outputs: a request is outstanding in FETCH and while draining in DROP
  always_comb begin
    mem_req  = (state_q == FETCH) || (state_q == DROP);
    mem_addr = addr_q;
    ir_valid = head_valid;
    ir_data  = head.data;
    ir_pc    = head.pc;
    ir_count = count;
  end

`ifdef MCU0_FETCH_STATS_EN
  logic [15:0] fetches_q, fetches_d;
  logic [15:0] flushes_q, flushes_d;

  // Statistic counters, wrapping modulo 2^16
  always_comb begin
    fetches_d = fetches_q + 16'(push);
    flushes_d = flushes_q + 16'(redirect);
  end

  // Statistic registers
  always_ff @(posedge clock) begin
    if (reset) begin
      fetches_q <= '0;
      flushes_q <= '0;
    end else begin
      fetches_q <= fetches_d;
      flushes_q <= flushes_d;
    end
  end

  assign stat_fetches = fetches_q;
  assign stat_flushes = flushes_q;
`endif

endmodule

// File: tb/tb_mcu0_fetch.sv
// tb_mcu0_fetch: directed table plus hand-written sequences for mcu0_fetch.
module tb_mcu0_fetch;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic        mem_req;
  logic [11:0] mem_addr;
  logic        mem_ack;
  logic [15:0] mem_rdata;
  logic        ir_valid;
  logic [15:0] ir_data;
  logic [11:0] ir_pc;
  logic        ir_ready = 1'b1;
  logic        redirect = 1'b0;
  logic [11:0] redirect_pc = 12'h000;
  logic [2:0]  ir_count;
`ifdef MCU0_FETCH_STATS_EN
  logic [15:0] stat_fetches;
  logic [15:0] stat_flushes;
`endif

  int   total = 0;
  int   bad   = 0;
  int   wait_states = 0;
  int   wcnt = 0;
  logic force_ack = 1'b0;

  mcu0_fetch #(.AW(12), .DEPTH(4), .RESET_PC(0)) dut (
    .clock       (clock),
    .reset       (reset),
    .mem_req     (mem_req),
    .mem_addr    (mem_addr),
    .mem_ack     (mem_ack),
    .mem_rdata   (mem_rdata),
    .ir_valid    (ir_valid),
    .ir_data     (ir_data),
    .ir_pc       (ir_pc),
    .ir_ready    (ir_ready),
    .redirect    (redirect),
    .redirect_pc (redirect_pc),
`ifdef MCU0_FETCH_STATS_EN
    .stat_fetches(stat_fetches),
    .stat_flushes(stat_flushes),
`endif
    .ir_count    (ir_count)
  );

  always #5 clock = ~clock;

  // Program memory contents
  function automatic logic [15:0] mem_word(input logic [11:0] a);
    case (a)
      12'h000: mem_word = 16'hF005;
      12'h001: mem_word = 16'h2010;
      12'h002: mem_word = 16'h3020;
      12'h003: mem_word = 16'h4030;
      12'h004: mem_word = 16'h5040;
      12'h005: mem_word = 16'h6050;
      default: mem_word = {4'h8, a};
    endcase
  endfunction

  // Memory model: ack after wait_states cycles of request
  assign mem_rdata = mem_word(mem_addr);
  assign mem_ack   = force_ack || (mem_req && (wcnt >= wait_states));

  always @(posedge clock) begin
    if (reset || !mem_req || mem_ack) wcnt <= 0;
    else                              wcnt <= wcnt + 1;
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic do_reset();
    @(negedge clock);
    reset     = 1'b1;
    redirect  = 1'b0;
    force_ack = 1'b0;
    @(negedge clock);
    reset = 1'b0;
  endtask

  typedef struct {
    logic        rst;
    logic        req;
    logic [11:0] addr;
    logic        v;
    logic [11:0] pc;
    logic [15:0] data;
    logic [2:0]  cnt;
  } vec_t;

  vec_t        vecs [10];
  logic [11:0] exp_pc [3];
  int          acks, npop, found, n;
  logic        seen;

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    // cycle-by-cycle startup with zero-wait memory and ir_ready=1
    vecs[0] = '{1'b1, 1'b0, 12'h000, 1'b0, 12'h000, 16'h0000, 3'd0};
    vecs[1] = '{1'b0, 1'b0, 12'h000, 1'b0, 12'h000, 16'h0000, 3'd0};
    vecs[2] = '{1'b0, 1'b1, 12'h000, 1'b0, 12'h000, 16'h0000, 3'd0};
    vecs[3] = '{1'b0, 1'b1, 12'h001, 1'b1, 12'h000, 16'hF005, 3'd1};
    vecs[4] = '{1'b0, 1'b1, 12'h002, 1'b1, 12'h001, 16'h2010, 3'd1};
    vecs[5] = '{1'b0, 1'b1, 12'h003, 1'b1, 12'h002, 16'h3020, 3'd1};
    vecs[6] = '{1'b0, 1'b1, 12'h004, 1'b1, 12'h003, 16'h4030, 3'd1};
    vecs[7] = '{1'b0, 1'b1, 12'h005, 1'b1, 12'h004, 16'h5040, 3'd1};
    vecs[8] = '{1'b0, 1'b1, 12'h006, 1'b1, 12'h005, 16'h6050, 3'd1};
    vecs[9] = '{1'b0, 1'b1, 12'h007, 1'b1, 12'h006, 16'h8006, 3'd1};

    for (int i = 0; i < 10; i++) begin
      @(negedge clock);
      reset = vecs[i].rst;
      chk($sformatf("v%0d_req", i),   32'(mem_req),  32'(vecs[i].req));
      chk($sformatf("v%0d_addr", i),  32'(mem_addr), 32'(vecs[i].addr));
      chk($sformatf("v%0d_valid", i), 32'(ir_valid), 32'(vecs[i].v));
      chk($sformatf("v%0d_pc", i),    32'(ir_pc),    32'(vecs[i].pc));
      chk($sformatf("v%0d_data", i),  32'(ir_data),  32'(vecs[i].data));
      chk($sformatf("v%0d_count", i), 32'(ir_count), 32'(vecs[i].cnt));
      $display("vec %0d: req=%0d addr=%h valid=%0d pc=%h data=%h count=%0d",
               i, mem_req, mem_addr, ir_valid, ir_pc, ir_data, ir_count);
    end

    // consumer stalled: queue fills to DEPTH, then drains and fetch resumes at 4
    ir_ready = 1'b0;
    wait_states = 0;
    do_reset();
    acks = 0;
    for (int i = 0; i < 12; i++) begin
      if (mem_req && mem_ack) acks++;
      @(negedge clock);
    end
    chk("full_acks", 32'(acks), 32'd4);
    chk("full_req", 32'(mem_req), 32'd0);
    chk("full_count", 32'(ir_count), 32'd4);
    $display("stall: acks=%0d count=%0d", acks, ir_count);
    ir_ready = 1'b1;
    npop = 0;
    seen = 1'b0;
    for (int i = 0; i < 20 && npop < 5; i++) begin
      if (mem_req && !seen) begin
        seen = 1'b1;
        chk("resume_addr", 32'(mem_addr), 32'h004);
      end
      if (ir_valid) begin
        chk($sformatf("drain_pc%0d", npop), 32'(ir_pc), 32'(npop));
        chk($sformatf("drain_data%0d", npop), 32'(ir_data), 32'(mem_word(12'(npop))));
        $display("drain: pc=%h data=%h", ir_pc, ir_data);
        npop++;
      end
      @(negedge clock);
    end
    chk("drain_pops", 32'(npop), 32'd5);
    chk("resume_seen", 32'(seen), 32'd1);

    // 2 wait states, redirect in first request cycle of address 0x003
    ir_ready = 1'b1;
    wait_states = 2;
    do_reset();
    found = 0;
    for (int i = 0; i < 60 && found == 0; i++) begin
      if (mem_req && mem_addr == 12'h003 && wcnt == 0) found = 1;
      else @(negedge clock);
    end
    chk("ws_reach", 32'(found), 32'd1);
    redirect = 1'b1;
    redirect_pc = 12'h040;
    chk("ws_noack", 32'(mem_ack), 32'd0);
    @(negedge clock);
    redirect = 1'b0;
    chk("ws_hold1_addr", 32'(mem_addr), 32'h003);
    chk("ws_hold1_req", 32'(mem_req), 32'd1);
    chk("ws_hold1_count", 32'(ir_count), 32'd0);
    chk("ws_hold1_valid", 32'(ir_valid), 32'd0);
    @(negedge clock);
    chk("ws_hold2_addr", 32'(mem_addr), 32'h003);
    chk("ws_hold2_ack", 32'(mem_ack), 32'd1);
    @(negedge clock);
    chk("ws_new_req", 32'(mem_req), 32'd1);
    chk("ws_new_addr", 32'(mem_addr), 32'h040);
    chk("ws_dropped_valid", 32'(ir_valid), 32'd0);
    found = 0;
    for (int i = 0; i < 20 && found == 0; i++) begin
      if (ir_valid) found = 1;
      else @(negedge clock);
    end
    chk("ws_deliver", 32'(found), 32'd1);
    chk("ws_first_pc", 32'(ir_pc), 32'h040);
    chk("ws_first_data", 32'(ir_data), 32'h8040);
    $display("waitstate redirect: first pc=%h data=%h", ir_pc, ir_data);

    // redirect coinciding with an ack, zero-wait memory
    ir_ready = 1'b0;
    wait_states = 0;
    do_reset();
    repeat (3) @(negedge clock);
    chk("ra_pre_addr", 32'(mem_addr), 32'h002);
    chk("ra_pre_ack", 32'(mem_ack), 32'd1);
    chk("ra_pre_count", 32'(ir_count), 32'd2);
    redirect = 1'b1;
    redirect_pc = 12'h100;
    @(negedge clock);
    redirect = 1'b0;
    chk("ra_count", 32'(ir_count), 32'd0);
    chk("ra_valid", 32'(ir_valid), 32'd0);
    chk("ra_req", 32'(mem_req), 32'd1);
    chk("ra_addr", 32'(mem_addr), 32'h100);
    @(negedge clock);
    chk("ra_next_valid", 32'(ir_valid), 32'd1);
    chk("ra_next_pc", 32'(ir_pc), 32'h100);
    chk("ra_next_data", 32'(ir_data), 32'h8100);
    $display("redirect+ack: pc=%h data=%h", ir_pc, ir_data);

    // address wrap from 0xFFE
    ir_ready = 1'b1;
    redirect = 1'b1;
    redirect_pc = 12'hFFE;
    @(negedge clock);
    redirect = 1'b0;
    exp_pc[0] = 12'hFFE;
    exp_pc[1] = 12'hFFF;
    exp_pc[2] = 12'h000;
    n = 0;
    for (int i = 0; i < 20 && n < 3; i++) begin
      if (ir_valid) begin
        chk($sformatf("wrap_pc%0d", n), 32'(ir_pc), 32'(exp_pc[n]));
        chk($sformatf("wrap_data%0d", n), 32'(ir_data), 32'(mem_word(exp_pc[n])));
        $display("wrap: pc=%h data=%h", ir_pc, ir_data);
        n++;
      end
      @(negedge clock);
    end
    chk("wrap_count", 32'(n), 32'd3);

    // reset mid-request with queue at 3, then a late ack in IDLE
    ir_ready = 1'b0;
    wait_states = 2;
    do_reset();
    found = 0;
    for (int i = 0; i < 60 && found == 0; i++) begin
      if (mem_req && ir_count == 3'd3) found = 1;
      else @(negedge clock);
    end
    chk("mr_reach", 32'(found), 32'd1);
    reset = 1'b1;
    @(negedge clock);
    reset = 1'b0;
    force_ack = 1'b1;
    chk("mr_req", 32'(mem_req), 32'd0);
    chk("mr_addr", 32'(mem_addr), 32'h000);
    chk("mr_valid", 32'(ir_valid), 32'd0);
    chk("mr_data", 32'(ir_data), 32'h0000);
    chk("mr_pc", 32'(ir_pc), 32'h000);
    chk("mr_count", 32'(ir_count), 32'd0);
`ifdef MCU0_FETCH_STATS_EN
    chk("mr_stat_fetches", 32'(stat_fetches), 32'd0);
    chk("mr_stat_flushes", 32'(stat_flushes), 32'd0);
`endif
    @(negedge clock);
    force_ack = 1'b0;
    chk("late_count", 32'(ir_count), 32'd0);
    chk("late_valid", 32'(ir_valid), 32'd0);
    chk("late_req", 32'(mem_req), 32'd1);
    chk("late_addr", 32'(mem_addr), 32'h000);
    $display("reset mid-request: req=%0d addr=%h count=%0d", mem_req, mem_addr, ir_count);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
